// File: rtl/rob_commit.sv
// ============================================================================
// Module   : rob_commit
// Brief    : Reorder buffer with in-order retirement, one commit per cycle.
//            Optional macro ROB_WB_ERR_EN enables the sticky wb_err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  input  logic [REG_W-1:0]           alloc_rd,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx,
  input  logic                       wb_valid,
  input  logic [$clog2(DEPTH)-1:0]   wb_idx,
  input  logic [DATA_W-1:0]          wb_value,
  output logic                       commit_valid,
  output logic                       commit_we,
  output logic [REG_W-1:0]           commit_rd,
  output logic [DATA_W-1:0]          commit_value,
  output logic [$clog2(DEPTH)-1:0]   commit_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       wb_err
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_idx_w + 1;

  logic [DEPTH-1:0]   r_busy;
  logic [DEPTH-1:0]   r_ready;
  logic [REG_W-1:0]   r_rd    [DEPTH];
  logic [DATA_W-1:0]  r_value [DEPTH];
  logic [c_idx_w-1:0] r_head;
  logic [c_idx_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  logic               r_commit_valid;
  logic [REG_W-1:0]   r_commit_rd;
  logic [DATA_W-1:0]  r_commit_value;
  logic [c_idx_w-1:0] r_commit_idx;

  logic w_full;
  logic w_alloc;
  logic w_commit;
  logic w_wb_hit;

  assign w_full   = (r_count == c_cnt_w'(DEPTH));
  assign w_alloc  = alloc_valid && !w_full;
  assign w_commit = r_busy[r_head] && r_ready[r_head];
  // A write-back aimed at the entry retiring this edge is discarded.
  assign w_wb_hit = wb_valid && r_busy[wb_idx] && !(w_commit && (wb_idx == r_head));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy         <= '0;
      r_ready        <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_wb_hit) begin
        r_ready[wb_idx] <= 1'b1;
      end
      r_count <= r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_commit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_alloc) begin
        r_rd[r_tail] <= alloc_rd;
      end
      if (w_wb_hit) begin
        r_value[wb_idx] <= wb_value;
      end
    end
  end

  // Commit payload holds across flush; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_commit_idx   <= '0;
    end else if (!flush && w_commit) begin
      r_commit_rd    <= r_rd[r_head];
      r_commit_value <= r_value[r_head];
      r_commit_idx   <= r_head;
    end
  end

`ifdef ROB_WB_ERR_EN
  logic r_wb_err;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wb_err <= 1'b0;
    end else if (wb_valid && (!r_busy[wb_idx] || r_ready[wb_idx])) begin
      r_wb_err <= 1'b1;
    end
  end

  assign wb_err = r_wb_err;
`else
  assign wb_err = 1'b0;
`endif

  assign alloc_ready  = !w_full;
  assign alloc_idx    = r_tail;
  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign commit_valid = r_commit_valid;
  assign commit_we    = r_commit_valid && (r_commit_rd != '0);
  assign commit_rd    = r_commit_rd;
  assign commit_value = r_commit_value;
  assign commit_idx   = r_commit_idx;

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
// ============================================================================
// Module   : tb_rob_commit
// Brief    : Self-checking bench for rob_commit; commits are scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_commit;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int IW     = 3;

  logic              clk = 1'b0;
  logic              rst, flush, alloc_valid, wb_valid;
  logic [REG_W-1:0]  alloc_rd;
  logic [IW-1:0]     wb_idx;
  logic [DATA_W-1:0] wb_value;
  logic              alloc_ready, commit_valid, commit_we, empty, wb_err;
  logic [IW-1:0]     alloc_idx, commit_idx;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic [IW:0]       count;

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_idx(commit_idx),
    .count(count), .empty(empty), .wb_err(wb_err)
  );

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
    logic [IW-1:0]     idx;
  } commit_t;

  commit_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model of the ROB, stepped once per edge by tick().
  logic              m_busy  [DEPTH];
  logic              m_ready [DEPTH];
  logic [REG_W-1:0]  m_rd    [DEPTH];
  logic [DATA_W-1:0] m_val   [DEPTH];
  int                m_head, m_tail, m_count;
  logic              m_err;

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_rd = '0; wb_valid = 0; wb_idx = '0; wb_value = '0;
  endtask

  task automatic tick();
    bit do_commit, do_alloc, wb_hit, wb_bad;
    int h;
    h         = m_head;
    do_commit = m_busy[h] && m_ready[h];
    do_alloc  = alloc_valid && (m_count != DEPTH);
    wb_hit    = wb_valid && m_busy[wb_idx] && !(do_commit && (int'(wb_idx) == h));
    wb_bad    = wb_valid && (!m_busy[wb_idx] || m_ready[wb_idx]);
    @(posedge clk);
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin m_busy[i] = 0; m_ready[i] = 0; end
      m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
    end else begin
      if (do_commit) begin
        exp_q.push_back('{rd: m_rd[h], value: m_val[h], idx: IW'(h)});
        m_busy[h] = 0; m_ready[h] = 0; m_head = (h + 1) % DEPTH;
      end
      if (do_alloc) begin
        m_busy[m_tail] = 1; m_ready[m_tail] = 0; m_rd[m_tail] = alloc_rd;
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (wb_hit) begin m_val[wb_idx] = wb_value; m_ready[wb_idx] = 1; end
      m_count = m_count + int'(do_alloc) - int'(do_commit);
`ifdef ROB_WB_ERR_EN
      if (wb_bad) m_err = 1;
`endif
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_commit got idx=%0d rd=%0d value=%h, required no commit",
                 commit_idx, commit_rd, commit_value);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        if ({commit_rd, commit_value, commit_idx, commit_we} !== {e.rd, e.value, e.idx, (e.rd != 0)}) begin
          failures++;
          $display("FAIL sb_commit got rd=%0d value=%h idx=%0d we=%0d, required rd=%0d value=%h idx=%0d we=%0d",
                   commit_rd, commit_value, commit_idx, commit_we, e.rd, e.value, e.idx, (e.rd != 0));
        end
      end
    end
  end

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    checks++;
    if ({alloc_ready, alloc_idx, count, empty, commit_valid, commit_we, wb_err} !== {1'b1, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ctrl got rdy=%0d idx=%0d cnt=%0d empty=%0d cv=%0d we=%0d err=%0d, required 1 0 0 1 0 0 0",
               alloc_ready, alloc_idx, count, empty, commit_valid, commit_we, wb_err);
    end
    checks++;
    if ({commit_rd, commit_value, commit_idx} !== '0) begin
      failures++;
      $display("FAIL reset_payload got rd=%0d value=%h idx=%0d, required all 0", commit_rd, commit_value, commit_idx);
    end
  endtask

  task automatic test_in_order();
    checks++;
    if (alloc_idx !== 3'd0) begin failures++; $display("FAIL alloc_idx0 got %0d required 0", alloc_idx); end
    alloc_valid = 1; alloc_rd = 5'd3; tick();
    checks++;
    if (alloc_idx !== 3'd1) begin failures++; $display("FAIL alloc_idx1 got %0d required 1", alloc_idx); end
    alloc_rd = 5'd4; tick(); idle(); tick(); tick();
    checks++;
    if ({count, commit_valid} !== {4'd2, 1'b0}) begin
      failures++; $display("FAIL pending_no_commit got cnt=%0d cv=%0d, required 2 0", count, commit_valid);
    end
    wb_valid = 1; wb_idx = 3'd1; wb_value = 32'hBEEF; tick();
    wb_idx = 3'd0; wb_value = 32'h1234; tick(); idle();
    checks++;
    if (commit_valid !== 1'b0) begin failures++; $display("FAIL wb_to_commit_latency got cv=1 required 0"); end
    tick();
    checks++;
    if ({commit_valid, commit_rd, commit_value, commit_idx} !== {1'b1, 5'd3, 32'h1234, 3'd0}) begin
      failures++;
      $display("FAIL first_retire got cv=%0d rd=%0d value=%h idx=%0d, required 1 3 00001234 0",
               commit_valid, commit_rd, commit_value, commit_idx);
    end
    tick();
    checks++;
    if ({commit_valid, commit_rd, commit_value, commit_idx} !== {1'b1, 5'd4, 32'hBEEF, 3'd1}) begin
      failures++;
      $display("FAIL second_retire got cv=%0d rd=%0d value=%h idx=%0d, required 1 4 0000beef 1",
               commit_valid, commit_rd, commit_value, commit_idx);
    end
    tick();
    checks++;
    if ({commit_valid, empty, commit_rd} !== {1'b0, 1'b1, 5'd4}) begin
      failures++; $display("FAIL after_drain got cv=%0d empty=%0d rd=%0d, required 0 1 4", commit_valid, empty, commit_rd);
    end
  endtask

  task automatic test_full_wrap();
    idle(); flush = 1; tick(); flush = 0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (alloc_idx !== IW'(i)) begin failures++; $display("FAIL fill_idx got %0d required %0d", alloc_idx, i); end
      alloc_valid = 1; alloc_rd = REG_W'(i + 8); tick();
    end
    alloc_rd = 5'd31; tick();
    checks++;
    if ({alloc_ready, count, alloc_idx} !== {1'b0, 4'd8, 3'd0}) begin
      failures++; $display("FAIL full_ignore got rdy=%0d cnt=%0d idx=%0d, required 0 8 0", alloc_ready, count, alloc_idx);
    end
    alloc_valid = 0; wb_valid = 1; wb_idx = 3'd0; wb_value = 32'hA0; tick(); wb_valid = 0;
    alloc_valid = 1; alloc_rd = 5'd20; tick();
    checks++;
    if ({commit_valid, count, alloc_ready, alloc_idx} !== {1'b1, 4'd7, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL full_commit_refuse got cv=%0d cnt=%0d rdy=%0d idx=%0d, required 1 7 1 0",
               commit_valid, count, alloc_ready, alloc_idx);
    end
    tick(); alloc_valid = 0;
    checks++;
    if ({count, alloc_idx} !== {4'd8, 3'd1}) begin
      failures++; $display("FAIL wrap_alloc got cnt=%0d idx=%0d, required 8 1", count, alloc_idx);
    end
    // Head is at 1; complete it last so all eight retire back to back.
    wb_valid = 1;
    for (int k = 0; k < DEPTH; k++) begin
      wb_idx = IW'((DEPTH - k) % DEPTH); wb_value = 32'h100 + ((DEPTH - k) % DEPTH); tick();
    end
    wb_valid = 0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      checks++;
      if ({commit_valid, commit_idx, count} !== {1'b1, IW'((k + 1) % DEPTH), 4'(DEPTH - 1 - k)}) begin
        failures++;
        $display("FAIL back_to_back step=%0d got cv=%0d idx=%0d cnt=%0d, required 1 %0d %0d",
                 k, commit_valid, commit_idx, count, (k + 1) % DEPTH, DEPTH - 1 - k);
      end
    end
  endtask

  task automatic test_rd_zero();
    alloc_valid = 1; alloc_rd = 5'd0; tick(); idle();
    wb_valid = 1; wb_idx = 3'(m_tail - 1); wb_value = 32'h55; tick(); idle(); tick();
    checks++;
    if ({commit_valid, commit_we, commit_rd, commit_value} !== {1'b1, 1'b0, 5'd0, 32'h55}) begin
      failures++;
      $display("FAIL rd_zero got cv=%0d we=%0d rd=%0d value=%h, required 1 0 0 00000055",
               commit_valid, commit_we, commit_rd, commit_value);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) begin alloc_valid = 1; alloc_rd = REG_W'(i); tick(); end
    idle();
    checks++;
    if (count !== 4'd5) begin failures++; $display("FAIL pre_flush_count got %0d required 5", count); end
    flush = 1; alloc_valid = 1; wb_valid = 1; wb_idx = IW'(m_head); wb_value = 32'hDEAD; tick(); idle();
    checks++;
    if ({count, empty, commit_valid, alloc_idx, alloc_ready} !== {4'd0, 1'b1, 1'b0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL flush got cnt=%0d empty=%0d cv=%0d idx=%0d rdy=%0d, required 0 1 0 0 1",
               count, empty, commit_valid, alloc_idx, alloc_ready);
    end
    tick(); tick();
    checks++;
    if ({commit_valid, count} !== {1'b0, 4'd0}) begin
      failures++; $display("FAIL post_flush_idle got cv=%0d cnt=%0d, required 0 0", commit_valid, count);
    end
  endtask

  task automatic test_wb_err();
    logic exp_err;
`ifdef ROB_WB_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    wb_valid = 1; wb_idx = 3'd6; wb_value = 32'h66; tick(); idle();
    checks++;
    if ({wb_err, m_err} !== {exp_err, exp_err}) begin
      failures++; $display("FAIL wb_err_set got %0d required %0d", wb_err, exp_err);
    end
    tick(); tick();
    checks++;
    if ({wb_err, commit_valid, count} !== {exp_err, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL wb_err_sticky got err=%0d cv=%0d cnt=%0d, required %0d 0 0", wb_err, commit_valid, count, exp_err);
    end
    flush = 1; tick(); idle();
    checks++;
    if (wb_err !== 1'b0) begin failures++; $display("FAIL wb_err_flush got %0d required 0", wb_err); end
  endtask

  initial begin
    idle(); rst = 1;
    m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
    for (int i = 0; i < DEPTH; i++) begin m_busy[i] = 0; m_ready[i] = 0; m_rd[i] = '0; m_val[i] = '0; end
    test_reset();
    test_in_order();
    test_full_wrap();
    test_rd_zero();
    test_flush();
    test_wb_err();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got %0d pending commits required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rob_commit.md
# rob_commit

Reorder buffer with in-order retirement: allocates an entry per dispatched instruction, accepts completed results from the write-back stage by ROB index, and retires the oldest entry once its result is present. It sits directly downstream of write-back; its commit outputs drive the architectural register file write port and the register-alias-table tag clear.

## Interface
Parameters:
- DEPTH, 8, number of ROB entries; power of two, at least 2
- DATA_W, 32, result width
- REG_W, 5, architectural register index width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard every entry (synchronous)
- alloc_valid  in  1  dispatch requests an entry
- alloc_rd  in  REG_W  destination register of the dispatched instruction
- alloc_ready  out  1  entry available (not full)
- alloc_idx  out  $clog2(DEPTH)  index granted on this cycle's allocation (= tail)
- wb_valid  in  1  write-back result valid
- wb_idx  in  $clog2(DEPTH)  ROB index of the result
- wb_value  in  DATA_W  result value
- commit_valid  out  1  one entry retired (registered, one-cycle pulse)
- commit_we  out  1  register file write enable (commit_valid && commit_rd != 0)
- commit_rd  out  REG_W  retired destination register
- commit_value  out  DATA_W  retired value
- commit_idx  out  $clog2(DEPTH)  retired ROB index, for RAT tag match/clear
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- wb_err  out  1  illegal write-back flag (see Configuration)

## Operation
- Per entry: busy, ready, rd, value. Pointers head, tail; count tracked separately.
- Allocation: fires when alloc_valid && alloc_ready. Sets busy, clears ready, stores alloc_rd at tail; tail increments modulo DEPTH. alloc_ready = (count != DEPTH). alloc_valid while full is ignored, no state change.
- Write-back: when wb_valid and entry wb_idx busy, store wb_value and set ready. Write-back to a non-busy entry is dropped. Write-back to an already-ready entry overwrites the value.
- Commit: at each edge, if head entry busy && ready, load commit_* registers from it, pulse commit_valid, clear busy/ready, increment head modulo DEPTH. At most one retirement per cycle. Otherwise commit_valid = 0; commit_rd/value/idx hold last values.
- Commit evaluates entry state as of before the edge: a write-back and the retirement of the same entry never occur at the same edge.
- Simultaneous allocate and commit: both occur; count unchanged. Allocate into a full ROB at the same edge as a commit is still refused (alloc_ready reflects pre-edge count).
- Flush: clears all busy/ready, head = tail = count = 0, commit_valid = 0 next cycle. Flush takes priority over allocation, write-back and commit in the same cycle.
- rst: same effect as flush; additionally commit_rd, commit_value, commit_idx = 0, wb_err = 0.

## Timing
- Reset values: alloc_ready 1, alloc_idx 0, count 0, empty 1, commit_valid 0, commit_we 0, commit_rd 0, commit_value 0, commit_idx 0, wb_err 0.
- alloc_ready, alloc_idx, count, empty: combinational from registered state, no input-to-output path.
- Write-back at edge N (ready set) -> commit sampled at edge N+1 -> commit_valid high during cycle after N+1 if entry is head. Minimum alloc-to-commit: 3 edges (alloc N, wb N+1, commit N+2).
- Back-to-back ready entries retire on consecutive cycles, one per edge.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

## Configuration
- ROB_WB_ERR_EN defined: wb_err is a sticky register set when wb_valid targets a non-busy entry or an already-ready entry; cleared only by rst or flush. The offending write-back is still dropped/overwritten as in Operation.
- ROB_WB_ERR_EN undefined: wb_err tied to 0; no detection logic.

## Test plan
- Reset then allocate rd=3,4 -> alloc_idx 0 then 1; count 2; no commit until write-back.
- wb idx1 value 0xBEEF, then idx0 value 0x1234 -> idx0 retires (rd 3, 0x1234) on first commit, idx1 (rd 4, 0xBEEF) on next cycle; out-of-order completion retires in order.
- Fill 8 entries -> alloc_ready 0, 9th alloc ignored; commit one while asserting alloc -> alloc refused that cycle, accepted the following cycle at alloc_idx 0 (wrap).
- Entry with rd=0 written 0x55 -> commit_valid 1, commit_we 0.
- Flush with 5 busy entries and concurrent wb_valid -> count 0, empty 1, no commit_valid, next alloc_idx 0.
- ROB_WB_ERR_EN: wb to idx 6 when unallocated -> wb_err 1 and stays 1; value not retired; flush clears it. Without macro wb_err stays 0.
